// File: rtl/mul_ctrl.sv
// Sequencing front-end for the two-stage Wallace-tree booth multiplier: registers
// operands onto the multiplier, captures the selected product half and holds it downstream.
module mul_ctrl #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      mul_x,
   output logic [31:0]      mul_y,
   output logic             mul_signed,
   input  logic [63:0]      mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RES  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_r;
   logic [1:0]       next_state_s;
   logic [1:0]       op_r;
   logic [TAG_W-1:0] tag_r;
   logic             accept_s;
   logic [31:0]      result_sel_s;

   // DONE with out_ready lets a new op enter in the same cycle as the transfer
   assign in_ready = !flush && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready));
   assign accept_s = in_valid && in_ready;
   assign busy     = (state_r != ST_IDLE);

   // next-state decode; flush overrides every transition
   always_comb begin
      next_state_s = state_r;
      if (flush) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  next_state_s = ST_CALC;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_CALC: next_state_s = ST_RES;
            ST_RES:  next_state_s = ST_DONE;
            ST_DONE: begin
               if (out_ready && accept_s) begin
                  next_state_s = ST_CALC;
               end else if (out_ready) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_DONE;
               end
            end
            default: next_state_s = ST_IDLE;
         endcase
      end
   end

   // product half select; reserved op 11 falls through to the low word
   always_comb begin
      result_sel_s = mul_result[31:0];
      if ((op_r == 2'b01) || (op_r == 2'b10)) begin
         result_sel_s = mul_result[63:32];
      end else begin
         result_sel_s = mul_result[31:0];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // operand registers; only an accepted op may disturb the multiplier inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         mul_x      <= 32'd0;
         mul_y      <= 32'd0;
         mul_signed <= 1'b0;
         op_r       <= 2'd0;
         tag_r      <= {TAG_W{1'b0}};
      end else if (accept_s) begin
         mul_x      <= in_src1;
         mul_y      <= in_src2;
         mul_signed <= (in_op != 2'b10);
         op_r       <= in_op;
         tag_r      <= in_tag;
      end
   end

   // result capture: the multiplier reloads every cycle, so this is the only stable copy
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_tag   <= {TAG_W{1'b0}};
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (state_r == ST_RES) begin
         out_valid <= 1'b1;
         out_data  <= result_sel_s;
         out_tag   <= tag_r;
      end else if ((state_r == ST_DONE) && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
